// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared widths, phase constants and volume codes for the synth voice path
package synth_pkg;
    localparam int SAMPLE_W         = 7;
    localparam int PHASE_W          = 10;
    localparam int VOL_W            = 2;
    // Generators update their accumulators at this phase and register one cycle later.
    localparam int GEN_UPDATE_PHASE = 8;

    typedef enum logic [VOL_W-1:0] {
        VOL_MUTE    = 2'd0,
        VOL_QUARTER = 2'd1,
        VOL_HALF    = 2'd2,
        VOL_FULL    = 2'd3
    } vol_e;
endpackage

// File: rtl/voice_scaler.sv
// rtl/voice_scaler.sv - combinational per-voice volume scaling by right shift
module voice_scaler
    import synth_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_sample,
    input  vol_e                i_vol,
    output logic [SAMPLE_W-1:0] o_scaled
);
    always_comb begin
        o_scaled = '0;
        case (i_vol)
            VOL_MUTE:    o_scaled = '0;
            VOL_QUARTER: o_scaled = i_sample >> 2;
            VOL_HALF:    o_scaled = i_sample >> 1;
            VOL_FULL:    o_scaled = i_sample;
            default:     o_scaled = '0;
        endcase
    end
endmodule

// File: rtl/pwm_audio_mixer.sv
// rtl/pwm_audio_mixer.sv - sample-rate phase master, voice mix pipeline and glitch-free PWM output
module pwm_audio_mixer
    import synth_pkg::*;
#(
    parameter int PERIOD        = 1024,
    parameter int CAPTURE_PHASE = 16,
    parameter int NUM_VOICES    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [NUM_VOICES*VOL_W-1:0]    voice_vol,
    output logic [PHASE_W-1:0]             subsample_phase,
    output logic                           sample_tick,
    output logic [PHASE_W-1:0]             duty,
    output logic                           pwm_out
);
    localparam int MIX_W = SAMPLE_W + 2;
    localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(PERIOD - 1);
    localparam logic [PHASE_W-1:0] CAP_PH  = PHASE_W'(CAPTURE_PHASE);
    localparam logic [PHASE_W-1:0] MIX_PH  = PHASE_W'(CAPTURE_PHASE + 1);
    localparam logic [PHASE_W-1:0] PEND_PH = PHASE_W'(CAPTURE_PHASE + 2);

    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  r_duty;
    logic [PHASE_W-1:0]  r_pending;
    logic [MIX_W-1:0]    r_mix;
    logic [SAMPLE_W-1:0] r_scaled [NUM_VOICES];
    logic                r_tick;
    logic                r_pwm;

    logic [SAMPLE_W-1:0] w_scaled [NUM_VOICES];
    logic [MIX_W-1:0]    w_mix_sum;
    logic                w_wrap;
    logic [PHASE_W-1:0]  w_next_phase;
    logic [PHASE_W-1:0]  w_duty_next;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        voice_scaler u_scaler (
            .i_sample (voice_samples[gi*SAMPLE_W +: SAMPLE_W]),
            .i_vol    (vol_e'(voice_vol[gi*VOL_W +: VOL_W])),
            .o_scaled (w_scaled[gi])
        );
    end

    always_comb begin
        w_mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_mix_sum = w_mix_sum + MIX_W'(r_scaled[i]);
        end
    end

    assign w_wrap       = (r_phase == LAST_PH);
    assign w_next_phase = w_wrap ? '0 : r_phase + 1'b1;
    // Compare against the duty that will be active at the next phase so the wrap cycle is clean.
    assign w_duty_next  = w_wrap ? r_pending : r_duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase   <= '0;
            r_duty    <= '0;
            r_pending <= '0;
            r_mix     <= '0;
            r_tick    <= 1'b0;
            r_pwm     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_scaled[i] <= '0;
            end
        end else if (ena) begin
            r_phase <= w_next_phase;
            r_tick  <= w_wrap;
            r_pwm   <= (w_next_phase < w_duty_next);
            if (w_wrap) begin
                r_duty <= r_pending;
            end
            if (r_phase == CAP_PH) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    r_scaled[i] <= w_scaled[i];
                end
            end
            if (r_phase == MIX_PH) begin
                r_mix <= w_mix_sum;
            end
            if (r_phase == PEND_PH) begin
                r_pending <= {r_mix, 1'b0};
            end
        end else begin
            r_tick <= 1'b0;
            r_pwm  <= 1'b0;
        end
    end

    assign subsample_phase = r_phase;
    assign sample_tick     = r_tick;
    assign duty            = r_duty;
    assign pwm_out         = r_pwm;
endmodule

// File: tb/tb_pwm_audio_mixer.sv
// tb/tb_pwm_audio_mixer.sv - randomized and directed self-checking bench for pwm_audio_mixer
module tb_pwm_audio_mixer;
    localparam int PERIOD = 1024;
    localparam int CAP    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [27:0] voice_samples = '0;
    logic [7:0]  voice_vol = '0;
    logic [9:0]  subsample_phase;
    logic        sample_tick;
    logic [9:0]  duty;
    logic        pwm_out;

    int vectors = 0;
    int miscompares = 0;
    int m_phase, m_duty, m_next_duty, m_tick, m_pwm;
    int hi, ticks;

    always #5 clk = ~clk;

    pwm_audio_mixer #(.PERIOD(PERIOD), .CAPTURE_PHASE(CAP), .NUM_VOICES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .voice_samples   (voice_samples),
        .voice_vol       (voice_vol),
        .subsample_phase (subsample_phase),
        .sample_tick     (sample_tick),
        .duty            (duty),
        .pwm_out         (pwm_out)
    );

    function automatic int scaled_of(int s, int v);
        case (v)
            0:       return 0;
            1:       return s / 4;
            2:       return s / 2;
            default: return s;
        endcase
    endfunction

    function automatic int duty_of(logic [27:0] vs, logic [7:0] vv);
        int t = 0;
        for (int i = 0; i < 4; i++) t += scaled_of(int'(vs[i*7 +: 7]), int'(vv[i*2 +: 2]));
        return 2 * t;
    endfunction

    // Period-level model: the captured mix becomes the duty at the next wrap.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_duty = 0; m_next_duty = 0; m_tick = 0; m_pwm = 0;
        end else if (ena) begin
            if (m_phase == CAP) m_next_duty = duty_of(voice_samples, voice_vol);
            m_tick  = (m_phase == PERIOD - 1) ? 1 : 0;
            m_phase = (m_phase + 1) % PERIOD;
            if (m_tick != 0) m_duty = m_next_duty;
            m_pwm = (m_phase < m_duty) ? 1 : 0;
        end else begin
            m_tick = 0;
            m_pwm  = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("phase", 32'(subsample_phase), m_phase);
        check("duty", 32'(duty), m_duty);
        check("tick", 32'(sample_tick), m_tick);
        check("pwm", 32'(pwm_out), m_pwm);
    end

    task automatic wait_phase(input int p);
        for (int i = 0; i < PERIOD + 64; i++) begin
            @(negedge clk);
            if (m_phase == p) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_phase: phase %0d not reached, got %0d", p, m_phase);
    endtask

    task automatic settle();
        wait_phase(0);
        wait_phase(0);
    endtask

    task automatic measure_high(output int n);
        wait_phase(0);
        n = 0;
        repeat (PERIOD) begin
            if (pwm_out === 1'b1) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_phase", 32'(subsample_phase), 0);
        check("rst_duty", 32'(duty), 0);
        check("rst_pwm", 32'(pwm_out), 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        ticks = 0; hi = 0;
        repeat (2 * PERIOD) begin
            @(negedge clk);
            if (sample_tick === 1'b1) ticks++;
            if (pwm_out === 1'b1) hi++;
        end
        check("muted_ticks", ticks, 2);
        check("muted_high", hi, 0);

        voice_samples = {7'd0, 7'd0, 7'd0, 7'd127};
        voice_vol     = 8'b00_00_00_11;
        settle();
        check("v0_duty", 32'(duty), 254);
        measure_high(hi);
        check("v0_high", hi, 254);

        voice_samples = {4{7'd127}};
        voice_vol     = 8'hFF;
        settle();
        check("full_duty", 32'(duty), 1016);
        measure_high(hi);
        check("full_high", hi, 1016);

        voice_samples = {4{7'd100}};
        voice_vol     = {2'd0, 2'd3, 2'd2, 2'd1};
        settle();
        check("mixvol_duty", 32'(duty), 350);
        measure_high(hi);
        check("mixvol_high", hi, 350);

        wait_phase(100);
        ena = 1'b0;
        repeat (50) begin
            @(negedge clk);
            check("hold_phase", 32'(subsample_phase), 100);
            check("hold_pwm", 32'(pwm_out), 0);
        end
        ena = 1'b1;
        check("hold_duty", 32'(duty), 350);

        voice_samples = {7'd0, 7'd0, 7'd0, 7'd127};
        voice_vol     = 8'b00_00_00_11;
        settle();
        wait_phase(15);
        voice_samples[6:0] = 7'd0;
        wait_phase(17);
        voice_samples[6:0] = 7'd127;
        wait_phase(0);
        check("glitch_duty", 32'(duty), 0);
        wait_phase(500);
        voice_samples[6:0] = 7'd0;
        wait_phase(0);
        check("late_change_duty", 32'(duty), 254);
        wait_phase(0);
        check("late_capture_duty", 32'(duty), 0);

        for (int n = 0; n < 6 * PERIOD; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) voice_samples = 28'($urandom);
            if ($urandom_range(0, 15) == 0) voice_vol = 8'($urandom);
            ena = ($urandom_range(0, 31) != 0);
        end
        ena = 1'b1;

        wait_phase(600);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_phase", 32'(subsample_phase), 0);
        check("async_rst_duty", 32'(duty), 0);
        check("async_rst_pwm", 32'(pwm_out), 0);
        check("async_rst_tick", 32'(sample_tick), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        voice_samples = {4{7'd127}};
        voice_vol     = 8'hFF;
        wait_phase(0);
        check("post_rst_duty", 32'(duty), 1016);
        wait_phase(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
